wb_merge: RTL

- Write-back merge unit on the initiator side of the GPR write port (WE/A3/WD/PC).
- Merges two result sources into the single GRF write slot, one write per cycle:
  - the in-order pipeline write-back, which can never stall;
  - a multi-cycle mul/div unit, through a valid/ready handshake and a small FIFO.
- Keeps a per-register pending scoreboard so issue logic can stall on RAW/WAW hazards against outstanding mul/div results.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_fifo.sv | 67 ++++++
 rtl/wb_merge.sv | 126 ++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back merge unit.
// Holds the queued-result entry layout and the occupancy width helper.
package wb_pkg;

    localparam int         WB_DEPTH = 4;
    localparam int         WB_DW    = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    // One queued mul/div result waiting for a free GRF write slot.
    typedef struct packed {
        logic [WB_DW-1:0] pc;
        logic [4:0]       a3;
        logic [WB_DW-1:0] wd;
    } wb_entry_t;

    // Occupancy needs one extra bit so that "full" (== depth) is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of queued mul/div results.
// Push is ignored when full and pop is ignored when empty, so the
// occupancy can never leave the range 0..DEPTH. DEPTH must be a power of
// two so the pointers wrap by plain binary overflow.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  wb_entry_t                     din,
    output wb_entry_t                     head,
    output logic                          full,
    output logic                          empty,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int CW = count_width(DEPTH);
    localparam int PW = $clog2(DEPTH);

    wb_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     occ;
    logic              do_push;
    logic              do_pop;

    assign full    = (occ == CW'(DEPTH));
    assign empty   = (occ == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign count   = occ;

    // Storage array: data only, no reset needed since the head is only
    // consumed while the buffer is non-empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; simultaneous push and pop keeps occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/wb_merge.sv
// Write-back merge unit in front of the GRF write port.
// The pipeline write-back always owns the slot when it carries a real
// destination; otherwise the oldest queued mul/div result is drained.
// A 32-entry pending scoreboard tracks mul/div destinations still in
// flight so issue logic can stall on hazards against them.
module wb_merge
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int DW    = WB_DW
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          P_WE,
    input  logic [4:0]                    P_A3,
    input  logic [DW-1:0]                 P_WD,
    input  logic [DW-1:0]                 P_PC,
    input  logic                          M_Valid,
    input  logic [4:0]                    M_A3,
    input  logic [DW-1:0]                 M_WD,
    input  logic [DW-1:0]                 M_PC,
    output logic                          M_Ready,
    input  logic                          Set_En,
    input  logic [4:0]                    Set_A,
    input  logic [4:0]                    Q1,
    input  logic [4:0]                    Q2,
    output logic                          Busy1,
    output logic                          Busy2,
    output logic                          WE,
    output logic [4:0]                    A3,
    output logic [DW-1:0]                 WD,
    output logic [DW-1:0]                 PC,
    output logic [count_width(DEPTH)-1:0] Count
);

    // Mul/div handshake: a result transfers on a rising edge where
    // M_Valid and M_Ready are both high. M_Ready only reflects whether the
    // FIFO has room before the edge (never a same-cycle pop), and the
    // producer holds M_A3/M_WD/M_PC stable while M_Valid waits on M_Ready.

    wb_entry_t   din;
    wb_entry_t   head;
    logic        full;
    logic        empty;
    logic        p_live;
    logic        push;
    logic        pop;
    logic [31:0] pending;
    logic [31:0] pending_nxt;

    // A pipeline write to r0 is not a real write and yields the slot.
    assign p_live = P_WE && (P_A3 != REG_ZERO);

    // The head drains only when the pipeline leaves the slot free.
    assign pop  = Reset && !p_live && !empty;
    assign push = Reset && M_Valid && !full;

    assign M_Ready = Reset && !full;

    assign din.pc = M_PC;
    assign din.a3 = M_A3;
    assign din.wd = M_WD;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .rst_n (Reset),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (Count)
    );

    // Slot arbitration: pipeline first, then FIFO head, else idle zeros.
    always_comb begin
        WE = 1'b0;
        A3 = REG_ZERO;
        WD = '0;
        PC = '0;
        if (Reset) begin
            if (p_live) begin
                WE = 1'b1;
                A3 = P_A3;
                WD = P_WD;
                PC = P_PC;
            end else if (!empty) begin
                // A queued r0 result is drained without touching the GRF.
                WE = (head.a3 != REG_ZERO);
                A3 = head.a3;
                WD = head.wd;
                PC = head.pc;
            end
        end
    end

    // Next scoreboard value: retire on pop, then mark on issue so that a
    // same-register set and clear in one cycle leaves the register pending.
    always_comb begin
        pending_nxt = pending;
        if (pop && (head.a3 != REG_ZERO)) begin
            pending_nxt[head.a3] = 1'b0;
        end
        if (Set_En && (Set_A != REG_ZERO)) begin
            pending_nxt[Set_A] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // Scoreboard register; reset forgets every outstanding result.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // Hazard queries reflect the scoreboard as it stands before the edge.
    assign Busy1 = Reset && pending[Q1];
    assign Busy2 = Reset && pending[Q2];

endmodule
